// File: rtl/vend_sequencer_if.sv
// Vending sequencer bus: coin/cancel/dispenser-ack inputs and registered status outputs.
// The master side is the coin mech, dispenser and panel; the slave side is the sequencer.
interface vend_sequencer_if #(
  parameter int CREDIT_W = 3
);
  logic [1:0]          coin;
  logic                cancel;
  logic                disp_ack;
  logic                disp_req;
  logic                change_pulse;
  logic                coin_reject;
  logic                busy;
  logic [CREDIT_W-1:0] credit;

  modport master (
    output coin, cancel, disp_ack,
    input  disp_req, change_pulse, coin_reject, credit, busy
  );

  modport slave (
    input  coin, cancel, disp_ack,
    output disp_req, change_pulse, coin_reject, credit, busy
  );
endinterface

// File: rtl/vend_sequencer.sv
// Beverage vending sequencer: credit accumulation, dispense handshake, change payout and idle refund.
//   state   | meaning
//   IDLE    | no credit, waiting for first valid coin
//   COLLECT | partial credit, idle timer running
//   VEND    | disp_req held until disp_ack
//   CHANGE  | paying back one 50c unit per cycle
module vend_sequencer #(
  parameter int PRICE_UNITS = 3,
  parameter int CREDIT_W    = 3,
  parameter int TIMEOUT     = 255,
  parameter int TO_W        = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  vend_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_VEND    = 2'd2,
    ST_CHANGE  = 2'd3
  } state_e;

  localparam logic [CREDIT_W-1:0] PRICE_C   = CREDIT_W'(PRICE_UNITS);
  localparam logic [TO_W-1:0]     TIMEOUT_C = TO_W'(TIMEOUT);

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic                coin_reject_q, coin_reject_d;

  logic                coin_ok;
  logic                coin_nz;
  logic [CREDIT_W-1:0] coin_val;
  logic [CREDIT_W-1:0] credit_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      credit_q      <= '0;
      to_cnt_q      <= '0;
      coin_reject_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      to_cnt_q      <= to_cnt_d;
      coin_reject_q <= coin_reject_d;
    end
  end

  always_comb begin
    coin_ok    = (bus.coin == 2'b01) || (bus.coin == 2'b10);
    coin_nz    = (bus.coin != 2'b00);
    coin_val   = (bus.coin == 2'b10) ? CREDIT_W'(2) :
                 (bus.coin == 2'b01) ? CREDIT_W'(1) : '0;
    credit_sum = credit_q + coin_val;

    state_d       = state_q;
    credit_d      = credit_q;
    to_cnt_d      = to_cnt_q;
    coin_reject_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        coin_reject_d = (bus.coin == 2'b11);
        if (coin_ok) begin
          credit_d = credit_sum;
          to_cnt_d = TIMEOUT_C;
          state_d  = (credit_sum >= PRICE_C) ? ST_VEND : ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        // cancel wins over a coin arriving in the same cycle; that coin goes back
        if (bus.cancel) begin
          coin_reject_d = coin_nz;
          to_cnt_d      = '0;
          state_d       = ST_CHANGE;
        end else if (coin_ok) begin
          credit_d = credit_sum;
          to_cnt_d = TIMEOUT_C;
          if (credit_sum >= PRICE_C) state_d = ST_VEND;
        end else begin
          coin_reject_d = (bus.coin == 2'b11);
          if (to_cnt_q <= TO_W'(1)) begin
            to_cnt_d = '0;
            state_d  = ST_CHANGE;
          end else begin
            to_cnt_d = to_cnt_q - TO_W'(1);
          end
        end
      end
      ST_VEND: begin
        coin_reject_d = coin_nz;
        if (bus.disp_ack) begin
          credit_d = credit_q - PRICE_C;
          state_d  = (credit_q > PRICE_C) ? ST_CHANGE : ST_IDLE;
        end
      end
      ST_CHANGE: begin
        coin_reject_d = coin_nz;
        if (credit_q != '0) credit_d = credit_q - CREDIT_W'(1);
        if (credit_q <= CREDIT_W'(1)) state_d = ST_IDLE;
      end
      default: begin
        state_d  = ST_IDLE;
        credit_d = '0;
        to_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    bus.disp_req     = (state_q == ST_VEND);
    bus.busy         = (state_q == ST_VEND) || (state_q == ST_CHANGE);
    bus.change_pulse = (state_q == ST_CHANGE) && (credit_q != '0);
    bus.coin_reject  = coin_reject_q;
    bus.credit       = credit_q;
  end

endmodule

// File: tb/tb_vend_sequencer.sv
// Scenario bench for vend_sequencer (PRICE_UNITS=3, TIMEOUT=4): per-cycle expected outputs
// are queued as stimulus is driven and compared one cycle later.
module tb_vend_sequencer;

  localparam int PRICE    = 3;
  localparam int CW       = 3;
  localparam int TO       = 4;
  localparam int TW       = 3;

  typedef struct packed {
    logic [CW-1:0] credit;
    logic          disp_req;
    logic          change_pulse;
    logic          coin_reject;
    logic          busy;
  } obs_t;

  typedef struct packed {
    logic [1:0] coin;
    logic       cancel;
    logic       ack;
    obs_t       exp;
  } step_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  obs_t exp_q[$];

  vend_sequencer_if #(.CREDIT_W(CW)) bus_if ();

  vend_sequencer #(
    .PRICE_UNITS(PRICE),
    .CREDIT_W   (CW),
    .TIMEOUT    (TO),
    .TO_W       (TW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if)
  );

  always #5 clk = ~clk;

  function automatic obs_t sample();
    obs_t o;
    o.credit       = bus_if.credit;
    o.disp_req     = bus_if.disp_req;
    o.change_pulse = bus_if.change_pulse;
    o.coin_reject  = bus_if.coin_reject;
    o.busy         = bus_if.busy;
    return o;
  endfunction

  function automatic step_t st(input logic [1:0] coin, input logic cancel, input logic ack,
                               input int credit, input logic dr, input logic cp,
                               input logic cr, input logic b);
    step_t s;
    s.coin             = coin;
    s.cancel           = cancel;
    s.ack              = ack;
    s.exp.credit       = CW'(credit);
    s.exp.disp_req     = dr;
    s.exp.change_pulse = cp;
    s.exp.coin_reject  = cr;
    s.exp.busy         = b;
    return s;
  endfunction

  task automatic drive(input step_t s);
    bus_if.coin     = s.coin;
    bus_if.cancel   = s.cancel;
    bus_if.disp_ack = s.ack;
    exp_q.push_back(s.exp);
  endtask

  task automatic idle_inputs();
    bus_if.coin     = 2'b00;
    bus_if.cancel   = 1'b0;
    bus_if.disp_ack = 1'b0;
  endtask

  // credit must never exceed PRICE+1; an underflow wraps high and trips the same check
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (bus_if.credit > CW'(PRICE + 1)) begin
        errors++;
        $display("FAIL credit_range got %0d want <= %0d", bus_if.credit, PRICE + 1);
      end
    end
  end

  task automatic test_reset();
    obs_t o;
    idle_inputs();
    rst_n = 1'b0;
    #3;
    o = sample();
    checks++;
    if (o !== obs_t'(0)) begin
      errors++;
      $display("FAIL reset_outputs got %h want %h", o, obs_t'(0));
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_exact_price();
    step_t tbl[$];
    obs_t  o, e;
    tbl.push_back(st(2'b01, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(st(2'b01, 0, 0, 2, 0, 0, 0, 0));
    tbl.push_back(st(2'b01, 0, 0, 3, 1, 0, 0, 1));
    tbl.push_back(st(2'b00, 0, 0, 3, 1, 0, 0, 1));
    tbl.push_back(st(2'b00, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(st(2'b00, 0, 0, 0, 0, 0, 0, 0));
    foreach (tbl[i]) begin
      drive(tbl[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      o = sample();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL exact_price step%0d got %h want %h", i, o, e);
      end
    end
    idle_inputs();
  endtask

  task automatic test_overpay_change();
    step_t tbl[$];
    obs_t  o, e;
    tbl.push_back(st(2'b10, 0, 0, 2, 0, 0, 0, 0));
    tbl.push_back(st(2'b10, 0, 0, 4, 1, 0, 0, 1));
    tbl.push_back(st(2'b00, 0, 1, 1, 0, 1, 0, 1));
    tbl.push_back(st(2'b00, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(st(2'b00, 0, 0, 0, 0, 0, 0, 0));
    foreach (tbl[i]) begin
      drive(tbl[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      o = sample();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL overpay step%0d got %h want %h", i, o, e);
      end
    end
    idle_inputs();
  endtask

  task automatic test_cancel();
    step_t tbl[$];
    obs_t  o, e;
    tbl.push_back(st(2'b01, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(st(2'b10, 1, 0, 1, 0, 1, 1, 1));
    tbl.push_back(st(2'b00, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(st(2'b00, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(st(2'b00, 0, 0, 0, 0, 0, 0, 0));
    foreach (tbl[i]) begin
      drive(tbl[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      o = sample();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL cancel step%0d got %h want %h", i, o, e);
      end
    end
    idle_inputs();
  endtask

  task automatic test_reject();
    step_t tbl[$];
    obs_t  o, e;
    tbl.push_back(st(2'b00, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(st(2'b11, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(st(2'b00, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(st(2'b10, 0, 0, 2, 0, 0, 0, 0));
    tbl.push_back(st(2'b01, 0, 0, 3, 1, 0, 0, 1));
    tbl.push_back(st(2'b01, 1, 0, 3, 1, 0, 1, 1));
    tbl.push_back(st(2'b00, 0, 0, 3, 1, 0, 0, 1));
    tbl.push_back(st(2'b00, 0, 1, 0, 0, 0, 0, 0));
    foreach (tbl[i]) begin
      drive(tbl[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      o = sample();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reject step%0d got %h want %h", i, o, e);
      end
    end
    idle_inputs();
  endtask

  task automatic test_timeout();
    step_t tbl[$];
    obs_t  o, e;
    tbl.push_back(st(2'b10, 0, 0, 2, 0, 0, 0, 0));
    repeat (3) tbl.push_back(st(2'b00, 0, 0, 2, 0, 0, 0, 0));
    tbl.push_back(st(2'b00, 0, 0, 2, 0, 1, 0, 1));
    tbl.push_back(st(2'b00, 0, 0, 1, 0, 1, 0, 1));
    tbl.push_back(st(2'b00, 0, 0, 0, 0, 0, 0, 0));
    foreach (tbl[i]) begin
      drive(tbl[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      o = sample();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL timeout step%0d got %h want %h", i, o, e);
      end
    end
    idle_inputs();
  endtask

  task automatic test_timeout_restart();
    step_t tbl[$];
    obs_t  o, e;
    tbl.push_back(st(2'b01, 0, 0, 1, 0, 0, 0, 0));
    repeat (3) tbl.push_back(st(2'b00, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(st(2'b01, 0, 0, 2, 0, 0, 0, 0));
    repeat (3) tbl.push_back(st(2'b00, 0, 0, 2, 0, 0, 0, 0));
    tbl.push_back(st(2'b00, 0, 0, 2, 0, 1, 0, 1));
    tbl.push_back(st(2'b00, 0, 0, 1, 0, 1, 0, 1));
    tbl.push_back(st(2'b00, 0, 0, 0, 0, 0, 0, 0));
    foreach (tbl[i]) begin
      drive(tbl[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      o = sample();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL timeout_restart step%0d got %h want %h", i, o, e);
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_vend();
    step_t tbl[$];
    obs_t  o, e;
    tbl.push_back(st(2'b10, 0, 0, 2, 0, 0, 0, 0));
    tbl.push_back(st(2'b10, 0, 0, 4, 1, 0, 0, 1));
    foreach (tbl[i]) begin
      drive(tbl[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      o = sample();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL rst_setup step%0d got %h want %h", i, o, e);
      end
    end
    idle_inputs();
    #2 rst_n = 1'b0;
    #1;
    o = sample();
    checks++;
    if (o !== obs_t'(0)) begin
      errors++;
      $display("FAIL rst_async got %h want %h", o, obs_t'(0));
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tbl.delete();
    tbl.push_back(st(2'b00, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(st(2'b01, 0, 0, 1, 0, 0, 0, 0));
    foreach (tbl[i]) begin
      drive(tbl[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      o = sample();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL rst_after step%0d got %h want %h", i, o, e);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_exact_price();
    test_overpay_change();
    test_cancel();
    test_reject();
    test_timeout();
    test_timeout_restart();
    test_reset_mid_vend();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
